sprite_position_ctrl: RTL

- Upstream neighbour of the VGA display stage.
- Converts four raw board pushbuttons into the sprite coordinates posX/posY that the pixel generator draws.
- Buttons are synchronised and debounced; position is updated once per video frame and clamped to the visible area.
- Holding a direction for long enough switches the sprite to a faster step.

---
 rtl/vga_pkg.sv | 44 ++++
 rtl/button_debouncer.sv | 40 ++++
 rtl/sprite_position_ctrl.sv | 118 +++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared VGA-side definitions: screen size, coordinate type, motion state enum
// and the single-axis step helper used by the sprite position controller.
// Build option: define SPRITE_POS_WRAP_EN to make step_axis wrap around the
// legal range instead of clamping at the edges.
package vga_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  typedef logic [9:0] coord_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SLOW = 2'd1,
    FAST = 2'd2
  } move_state_t;

  // Move one axis by step. inc/dec are already resolved, so at most one is set.
  // Arithmetic runs in 11 bits so pos+step never wraps before the edge test.
  function automatic coord_t step_axis(input coord_t      pos,
                                       input logic [10:0] step,
                                       input logic [10:0] max_pos,
                                       input logic        inc,
                                       input logic        dec);
    logic [10:0] p;
    logic [10:0] r;
    p = {1'b0, pos};
    r = p;
`ifdef SPRITE_POS_WRAP_EN
    // Range is 0..max_pos, so wrapping is modulo (max_pos + 1).
    if (inc)
      r = (p + step > max_pos) ? p + step - max_pos - 11'd1 : p + step;
    else if (dec)
      r = (p < step) ? max_pos - step + p + 11'd1 : p - step;
`else
    if (inc)
      r = (p + step > max_pos) ? max_pos : p + step;
    else if (dec)
      r = (p < step) ? 11'd0 : p - step;
`endif
    return r[9:0];
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchroniser followed by a level debouncer for one pushbutton.
// The debounced level flips only after the synced input has disagreed with it
// for DEBOUNCE_CYCLES consecutive clocks; any agreeing cycle restarts the count.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic level
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  // Synchronise the raw button and qualify changes with the stability counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sprite_position_ctrl.sv
// Turns four raw pushbuttons into the sprite's top-left coordinate, updated
// once per video frame. A direction held for HOLD_FRAMES frames switches from
// STEP to FAST_STEP pixels per frame.
// Build option: SPRITE_POS_WRAP_EN wraps the position instead of clamping.
//
// state | meaning
// IDLE  | no resolved direction, sprite stationary
// SLOW  | moving STEP px/frame, counting held frames
// FAST  | moving FAST_STEP px/frame until released
module sprite_position_ctrl
  import vga_pkg::*;
#(
  parameter int SCREEN_W        = vga_pkg::SCREEN_W,
  parameter int SCREEN_H        = vga_pkg::SCREEN_H,
  parameter int SPRITE_W        = 32,
  parameter int SPRITE_H        = 32,
  parameter int INIT_X          = 304,
  parameter int INIT_Y          = 224,
  parameter int STEP            = 2,
  parameter int FAST_STEP       = 6,
  parameter int HOLD_FRAMES     = 30,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       frame_tick,
  output logic [9:0] posX,
  output logic [9:0] posY,
  output logic       moving
);

  localparam logic [10:0] MAX_X  = 11'(SCREEN_W - SPRITE_W);
  localparam logic [10:0] MAX_Y  = 11'(SCREEN_H - SPRITE_H);
  localparam logic [10:0] STEP_S = 11'(STEP);
  localparam logic [10:0] STEP_F = 11'(FAST_STEP);
  localparam int          HCW    = $clog2(HOLD_FRAMES + 1);

  logic up_db, down_db, left_db, right_db;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
    .clk(clk), .reset(reset), .btn_raw(btn_up), .level(up_db));
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
    .clk(clk), .reset(reset), .btn_raw(btn_down), .level(down_db));
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left (
    .clk(clk), .reset(reset), .btn_raw(btn_left), .level(left_db));
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right (
    .clk(clk), .reset(reset), .btn_raw(btn_right), .level(right_db));

  // Opposing buttons on one axis cancel each other.
  logic inc_x, dec_x, inc_y, dec_y, active;
  assign inc_x  = right_db & ~left_db;
  assign dec_x  = left_db & ~right_db;
  assign inc_y  = down_db & ~up_db;
  assign dec_y  = up_db & ~down_db;
  assign active = inc_x | dec_x | inc_y | dec_y;

  move_state_t    state;
  logic [HCW-1:0] hold_cnt;

  // Motion FSM and position registers; everything advances only on frame_tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      hold_cnt <= '0;
      posX     <= 10'(INIT_X);
      posY     <= 10'(INIT_Y);
      moving   <= 1'b0;
    end else if (frame_tick) begin
      case (state)
        IDLE: begin
          if (active) begin
            state    <= SLOW;
            hold_cnt <= HCW'(1);
            posX     <= step_axis(posX, STEP_S, MAX_X, inc_x, dec_x);
            posY     <= step_axis(posY, STEP_S, MAX_Y, inc_y, dec_y);
            moving   <= 1'b1;
          end
        end
        SLOW: begin
          if (!active) begin
            state    <= IDLE;
            hold_cnt <= '0;
            moving   <= 1'b0;
          end else begin
            if (hold_cnt == HCW'(HOLD_FRAMES - 1))
              state <= FAST;
            else
              hold_cnt <= hold_cnt + 1'b1;
            posX   <= step_axis(posX, STEP_S, MAX_X, inc_x, dec_x);
            posY   <= step_axis(posY, STEP_S, MAX_Y, inc_y, dec_y);
            moving <= 1'b1;
          end
        end
        FAST: begin
          if (!active) begin
            state    <= IDLE;
            hold_cnt <= '0;
            moving   <= 1'b0;
          end else begin
            posX   <= step_axis(posX, STEP_F, MAX_X, inc_x, dec_x);
            posY   <= step_axis(posY, STEP_F, MAX_Y, inc_y, dec_y);
            moving <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          hold_cnt <= '0;
          moving   <= 1'b0;
        end
      endcase
    end
  end

endmodule
